hawk_axi4_line_master: RTL and testbench
========================================

HAWK_AXI4_LINE_MASTER -- requirements
Module: hawk_axi4_line_master

Interface
REQ-001 Parameter AXI_ID, default 6'd0: ID driven on axi_awid/axi_arid and expected on axi_bid/axi_rid.
REQ-002 AXI data width SHALL be fixed at 256 bits; one cache line SHALL be 512 bits, transferred as 2 beats.
REQ-003 Clock clk; reset rst_n, asynchronous, active-low.
REQ-004 Ports (name  direction  width  meaning):
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- req_valid / req_ready  in / out  1 / 1  line request handshake
- req_wr  in  1  1=write, 0=read
- req_addr  in  64  byte address; bits [5:0] ignored
- req_wdata  in  512  write line; beat0=[255:0], beat1=[511:256]
- req_wstrb  in  64  byte strobes; beat0=[31:0], beat1=[63:32]
- rsp_valid / rsp_ready  out / in  1 / 1  completion handshake
- rsp_rdata  out  512  read line; 0 after writes
- rsp_err  out  1  bad resp, ID mismatch or rlast error
- axi_awvalid, axi_awready, axi_awid[5:0], axi_awaddr[63:0], axi_awlen[7:0], axi_awsize[2:0], axi_awburst[1:0]  out/in  AW channel
- axi_wvalid, axi_wready, axi_wdata[255:0], axi_wstrb[31:0], axi_wlast  out/in  W channel
- axi_bvalid, axi_bready, axi_bid[5:0], axi_bresp[1:0]  in/out  B channel
- axi_arvalid, axi_arready, axi_arid[5:0], axi_araddr[63:0], axi_arlen[7:0], axi_arsize[2:0], axi_arburst[1:0]  out/in  AR channel
- axi_rvalid, axi_rready, axi_rid[5:0], axi_rdata[255:0], axi_rresp[1:0], axi_rlast  in/out  R channel

Function
REQ-005 FSM states: IDLE, WR, WR_B, RD_AR, RD_R, RSP; exactly one transaction outstanding.
REQ-006 req_ready SHALL be 1 only in IDLE; on req_valid&req_ready, capture addr/wdata/wstrb/wr, clear rsp_err; go to WR if req_wr, else RD_AR.
REQ-007 Captured address SHALL have bits [5:0] forced to 0; awaddr/araddr = that value.
REQ-008 awlen/arlen = 8'd1, awsize/arsize = 3'd5, awburst/arburst = 2'b01 (INCR), awid/arid = AXI_ID, constant.
REQ-009 WR: axi_awvalid and axi_wvalid SHALL both assert on the first WR cycle; awvalid held until awready sampled high, then deasserted permanently for that transaction.
REQ-010 W beats: beat counter 0..1; wdata/wstrb select beat; wlast=1 only on beat 1; counter advances on wvalid&wready; wvalid drops after beat 1 accepted.
REQ-011 AW and W completion SHALL be independent (either order, or same cycle); WR->WR_B only after both done.
REQ-012 WR_B: axi_bready=1; on bvalid, set rsp_err if bresp!=0 or bid!=AXI_ID, rsp_rdata=0, go to RSP.
REQ-013 RD_AR: axi_arvalid=1 until arready; then RD_R with beat counter 0.
REQ-014 RD_R: axi_rready=1; each rvalid beat stored into rsp_rdata[255:0] (beat0) or [511:256] (beat1); error if rresp!=0, rid!=AXI_ID, rlast=1 on beat0 or rlast=0 on beat1; after beat 1 go to RSP.
REQ-015 RSP: rsp_valid=1, rsp_rdata/rsp_err stable until rsp_ready; then IDLE; req_ready not asserted in the same cycle.
REQ-016 bready, rready SHALL be 0 outside WR_B, RD_R; valid handshakes outside those states ignored.
REQ-017 No combinational path from any AXI input or rsp_ready to any output; all outputs registered.

Reset
REQ-018 On rst_n low (any state, incl. mid-burst): state IDLE, all valid/ready outputs 0, counters 0, rsp_rdata 0, rsp_err 0; req_ready rises the first clk after deassertion; no partial transaction resumed.

Verification
REQ-019 Write addr 0x1047, wdata beat0=0xAA.., beat1=0x55.., wstrb all 1, awready/wready always 1, bresp=0 after 3 cycles -> awaddr 0x1040, awlen 1, wlast on beat 1 only, rsp_valid with rsp_err=0.
REQ-020 Write with awready delayed 5 cycles, wready=1 -> both W beats complete before AW; B accepted only after AW; single rsp.
REQ-021 Read addr 0x2000, memory returns 0x11.. then 0x22.. with rlast on beat 2, rready stall via rvalid gaps -> rsp_rdata = {0x22..,0x11..}, rsp_err=0.
REQ-022 Read with rresp=2'b10 on beat 1, or bid=AXI_ID+1 on write -> rsp_err=1, FSM returns to IDLE after rsp_ready.
REQ-023 rsp_ready held 0 for 4 cycles -> rsp_valid/rsp_rdata stable, req_ready stays 0, no new AXI valid.
REQ-024 rst_n pulsed low during W beat 1 -> all AXI valids 0 immediately, req_ready=1 next clk, next request completes normally.

Source files
------------

// File: rtl/hawk_axi4_line_master.sv
// hawk_axi4_line_master: single-outstanding 512-bit cache-line master over a 256-bit AXI4 bus (2-beat INCR bursts)
module hawk_axi4_line_master #(
    parameter logic [5:0] AXI_ID = 6'd0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_wr,
    input  logic [63:0]  req_addr,
    input  logic [511:0] req_wdata,
    input  logic [63:0]  req_wstrb,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [511:0] rsp_rdata,
    output logic         rsp_err,
    output logic         axi_awvalid,
    input  logic         axi_awready,
    output logic [5:0]   axi_awid,
    output logic [63:0]  axi_awaddr,
    output logic [7:0]   axi_awlen,
    output logic [2:0]   axi_awsize,
    output logic [1:0]   axi_awburst,
    output logic         axi_wvalid,
    input  logic         axi_wready,
    output logic [255:0] axi_wdata,
    output logic [31:0]  axi_wstrb,
    output logic         axi_wlast,
    input  logic         axi_bvalid,
    output logic         axi_bready,
    input  logic [5:0]   axi_bid,
    input  logic [1:0]   axi_bresp,
    output logic         axi_arvalid,
    input  logic         axi_arready,
    output logic [5:0]   axi_arid,
    output logic [63:0]  axi_araddr,
    output logic [7:0]   axi_arlen,
    output logic [2:0]   axi_arsize,
    output logic [1:0]   axi_arburst,
    input  logic         axi_rvalid,
    output logic         axi_rready,
    input  logic [5:0]   axi_rid,
    input  logic [255:0] axi_rdata,
    input  logic [1:0]   axi_rresp,
    input  logic         axi_rlast
);
    typedef enum logic [2:0] {IDLE, WR, WR_B, RD_AR, RD_R, RSP} state_t;
    state_t state_q, state_d;
    logic         live_q;
    logic [63:0]  addr_q, addr_d;
    logic [511:0] wdata_q, wdata_d;
    logic [63:0]  wstrb_q, wstrb_d;
    logic         beat_q, beat_d;
    logic         aw_done_q, aw_done_d;
    logic         w_done_q, w_done_d;
    logic [511:0] rdata_q, rdata_d;
    logic         err_q, err_d;
    logic         accept, aw_hs, w_hs, aw_fin, w_fin;

    assign accept = req_valid && req_ready;
    assign aw_hs = axi_awvalid && axi_awready;
    assign w_hs = axi_wvalid && axi_wready;
    assign aw_fin = aw_done_q || aw_hs;
    assign w_fin = w_done_q || (w_hs && beat_q);
    assign axi_awid = AXI_ID;
    assign axi_arid = AXI_ID;
    assign axi_awaddr = addr_q;
    assign axi_araddr = addr_q;
    assign axi_awlen = 8'd1;
    assign axi_arlen = 8'd1;
    assign axi_awsize = 3'd5;
    assign axi_arsize = 3'd5;
    assign axi_awburst = 2'b01;
    assign axi_arburst = 2'b01;
    assign rsp_rdata = rdata_q;
    assign rsp_err = err_q;

    // State register; live_q holds req_ready low until the first clock after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            live_q <= 1'b0;
        end else begin
            state_q <= state_d;
            live_q <= 1'b1;
        end
    end

    // Next-state: AW and W finish independently, WR leaves only once both are done
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = req_wr ? WR : RD_AR;
            WR:      if (aw_fin && w_fin) state_d = WR_B;
            WR_B:    if (axi_bvalid) state_d = RSP;
            RD_AR:   if (axi_arready) state_d = RD_R;
            RD_R:    if (axi_rvalid && beat_q) state_d = RSP;
            RSP:     if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode from registers only, so no input reaches an output combinationally
    always_comb begin
        req_ready = live_q && state_q == IDLE;
        axi_awvalid = state_q == WR && !aw_done_q;
        axi_wvalid = state_q == WR && !w_done_q;
        axi_bready = state_q == WR_B;
        axi_arvalid = state_q == RD_AR;
        axi_rready = state_q == RD_R;
        rsp_valid = state_q == RSP;
        axi_wdata = beat_q ? wdata_q[511:256] : wdata_q[255:0];
        axi_wstrb = beat_q ? wstrb_q[63:32] : wstrb_q[31:0];
        axi_wlast = axi_wvalid && beat_q;
    end

    // Datapath next-state: request capture, beat tracking, read assembly and error accumulation
    always_comb begin
        addr_d = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        beat_d = beat_q;
        aw_done_d = aw_done_q || aw_hs;
        w_done_d = w_done_q;
        rdata_d = rdata_q;
        err_d = err_q;
        if (accept) begin
            addr_d = req_addr & ~64'h3f;
            wdata_d = req_wdata;
            wstrb_d = req_wstrb;
            beat_d = 1'b0;
            aw_done_d = 1'b0;
            w_done_d = 1'b0;
            err_d = 1'b0;
        end
        if (w_hs) begin
            beat_d = ~beat_q;
            w_done_d = w_done_q || beat_q;
        end
        if (axi_bready && axi_bvalid) begin
            err_d = err_q || axi_bresp != 2'b00 || axi_bid != AXI_ID;
            rdata_d = '0;
        end
        if (axi_rready && axi_rvalid) begin
            rdata_d = beat_q ? {axi_rdata, rdata_q[255:0]} : {rdata_q[511:256], axi_rdata};
            err_d = err_q || axi_rresp != 2'b00 || axi_rid != AXI_ID || axi_rlast != beat_q;
            beat_d = ~beat_q;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            beat_q <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q <= 1'b0;
            rdata_q <= '0;
            err_q <= 1'b0;
        end else begin
            addr_q <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            beat_q <= beat_d;
            aw_done_q <= aw_done_d;
            w_done_q <= w_done_d;
            rdata_q <= rdata_d;
            err_q <= err_d;
        end
    end
endmodule

// File: tb/tb_hawk_axi4_line_master.sv
// tb_hawk_axi4_line_master: directed scenario tests for the AXI4 line master
module tb_hawk_axi4_line_master;
    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         req_valid = 1'b0, req_ready, req_wr = 1'b0;
    logic [63:0]  req_addr = '0;
    logic [511:0] req_wdata = '0;
    logic [63:0]  req_wstrb = '0;
    logic         rsp_valid, rsp_ready = 1'b0, rsp_err;
    logic [511:0] rsp_rdata;
    logic         axi_awvalid, axi_awready = 1'b0;
    logic [5:0]   axi_awid;
    logic [63:0]  axi_awaddr;
    logic [7:0]   axi_awlen;
    logic [2:0]   axi_awsize;
    logic [1:0]   axi_awburst;
    logic         axi_wvalid, axi_wready = 1'b0, axi_wlast;
    logic [255:0] axi_wdata;
    logic [31:0]  axi_wstrb;
    logic         axi_bvalid = 1'b0, axi_bready;
    logic [5:0]   axi_bid = '0;
    logic [1:0]   axi_bresp = '0;
    logic         axi_arvalid, axi_arready = 1'b0;
    logic [5:0]   axi_arid;
    logic [63:0]  axi_araddr;
    logic [7:0]   axi_arlen;
    logic [2:0]   axi_arsize;
    logic [1:0]   axi_arburst;
    logic         axi_rvalid = 1'b0, axi_rready, axi_rlast = 1'b0;
    logic [5:0]   axi_rid = '0;
    logic [255:0] axi_rdata = '0;
    logic [1:0]   axi_rresp = '0;
    int errors = 0;
    int checks = 0;
    localparam logic [255:0] W0 = {32{8'hAA}};
    localparam logic [255:0] W1 = {32{8'h55}};
    localparam logic [255:0] R0 = {32{8'h11}};
    localparam logic [255:0] R1 = {32{8'h22}};

    always #5 clk = ~clk;

    hawk_axi4_line_master #(.AXI_ID(6'd0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awid(axi_awid), .axi_awaddr(axi_awaddr),
        .axi_awlen(axi_awlen), .axi_awsize(axi_awsize), .axi_awburst(axi_awburst),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
        .axi_wlast(axi_wlast),
        .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bid(axi_bid), .axi_bresp(axi_bresp),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_arid(axi_arid), .axi_araddr(axi_araddr),
        .axi_arlen(axi_arlen), .axi_arsize(axi_arsize), .axi_arburst(axi_arburst),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rid(axi_rid), .axi_rdata(axi_rdata),
        .axi_rresp(axi_rresp), .axi_rlast(axi_rlast)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input logic wr, input logic [63:0] a, input logic [511:0] d, input logic [63:0] s);
        req_valid = 1'b1; req_wr = wr; req_addr = a; req_wdata = d; req_wstrb = s;
        tick;
        req_valid = 1'b0;
    endtask

    task automatic finish_rsp;
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick;
        tick;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready got %0b want 0", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %0b want 0", rsp_valid); end
        checks++; if (axi_awvalid !== 1'b0 || axi_wvalid !== 1'b0 || axi_arvalid !== 1'b0) begin errors++; $display("FAIL rst_axi_valids got aw=%0b w=%0b ar=%0b want 0", axi_awvalid, axi_wvalid, axi_arvalid); end
        checks++; if (axi_bready !== 1'b0 || axi_rready !== 1'b0) begin errors++; $display("FAIL rst_axi_readys got b=%0b r=%0b want 0", axi_bready, axi_rready); end
        checks++; if (rsp_rdata !== 512'd0 || rsp_err !== 1'b0) begin errors++; $display("FAIL rst_rsp_data got err=%0b rdata=%h want 0", rsp_err, rsp_rdata); end
        rst_n = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_release_early got %0b want 0", req_ready); end
        @(posedge clk);
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %0b want 1", req_ready); end
    endtask

    task automatic test_write_basic;
        axi_awready = 1'b1; axi_wready = 1'b1;
        send_req(1'b1, 64'h1047, {W1, W0}, '1);
        checks++; if (axi_awvalid !== 1'b1 || axi_wvalid !== 1'b1) begin errors++; $display("FAIL wr_first_valids got aw=%0b w=%0b want 1 1", axi_awvalid, axi_wvalid); end
        checks++; if (axi_awaddr !== 64'h1040) begin errors++; $display("FAIL wr_awaddr got %h want 1040", axi_awaddr); end
        checks++; if (axi_awlen !== 8'd1 || axi_awsize !== 3'd5 || axi_awburst !== 2'b01 || axi_awid !== 6'd0) begin errors++; $display("FAIL wr_aw_attr got len=%0d size=%0d burst=%0d id=%0d want 1 5 1 0", axi_awlen, axi_awsize, axi_awburst, axi_awid); end
        checks++; if (axi_wdata !== W0 || axi_wlast !== 1'b0 || axi_wstrb !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wr_beat0 got last=%0b strb=%h data=%h", axi_wlast, axi_wstrb, axi_wdata); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL wr_req_ready_busy got %0b want 0", req_ready); end
        tick;
        checks++; if (axi_awvalid !== 1'b0 || axi_wvalid !== 1'b1) begin errors++; $display("FAIL wr_beat1_valids got aw=%0b w=%0b want 0 1", axi_awvalid, axi_wvalid); end
        checks++; if (axi_wdata !== W1 || axi_wlast !== 1'b1) begin errors++; $display("FAIL wr_beat1 got last=%0b data=%h", axi_wlast, axi_wdata); end
        tick;
        checks++; if (axi_wvalid !== 1'b0 || axi_bready !== 1'b1) begin errors++; $display("FAIL wr_b_phase got w=%0b bready=%0b want 0 1", axi_wvalid, axi_bready); end
        tick;
        tick;
        axi_bvalid = 1'b1;
        tick;
        axi_bvalid = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 512'd0) begin errors++; $display("FAIL wr_rsp got valid=%0b err=%0b want 1 0", rsp_valid, rsp_err); end
        checks++; if (axi_bready !== 1'b0) begin errors++; $display("FAIL wr_bready_after got %0b want 0", axi_bready); end
        finish_rsp;
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL wr_idle got rsp_valid=%0b req_ready=%0b want 0 1", rsp_valid, req_ready); end
    endtask

    task automatic test_write_bid_err;
        axi_awready = 1'b1; axi_wready = 1'b1;
        send_req(1'b1, 64'h3000, {W0, W1}, '1);
        tick;
        tick;
        axi_bvalid = 1'b1; axi_bid = 6'd1;
        tick;
        axi_bvalid = 1'b0; axi_bid = 6'd0;
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin errors++; $display("FAIL bid_err_rsp got valid=%0b err=%0b want 1 1", rsp_valid, rsp_err); end
        finish_rsp;
        checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL bid_err_idle got req_ready=%0b rsp_valid=%0b want 1 0", req_ready, rsp_valid); end
    endtask

    task automatic test_read;
        axi_arready = 1'b0;
        send_req(1'b0, 64'h2000, '0, '0);
        checks++; if (axi_arvalid !== 1'b1 || axi_araddr !== 64'h2000) begin errors++; $display("FAIL rd_ar got valid=%0b addr=%h want 1 2000", axi_arvalid, axi_araddr); end
        checks++; if (axi_arlen !== 8'd1 || axi_arsize !== 3'd5 || axi_arburst !== 2'b01 || axi_arid !== 6'd0) begin errors++; $display("FAIL rd_ar_attr got len=%0d size=%0d burst=%0d id=%0d want 1 5 1 0", axi_arlen, axi_arsize, axi_arburst, axi_arid); end
        checks++; if (axi_awvalid !== 1'b0 || axi_rready !== 1'b0) begin errors++; $display("FAIL rd_ar_others got aw=%0b rready=%0b want 0 0", axi_awvalid, axi_rready); end
        tick;
        checks++; if (axi_arvalid !== 1'b1) begin errors++; $display("FAIL rd_ar_hold got %0b want 1", axi_arvalid); end
        axi_arready = 1'b1;
        tick;
        axi_arready = 1'b0;
        checks++; if (axi_arvalid !== 1'b0 || axi_rready !== 1'b1) begin errors++; $display("FAIL rd_r_phase got ar=%0b rready=%0b want 0 1", axi_arvalid, axi_rready); end
        tick;
        axi_rvalid = 1'b1; axi_rdata = R0; axi_rlast = 1'b0;
        tick;
        axi_rvalid = 1'b0;
        checks++; if (rsp_valid !== 1'b0 || axi_rready !== 1'b1) begin errors++; $display("FAIL rd_mid got rsp_valid=%0b rready=%0b want 0 1", rsp_valid, axi_rready); end
        tick;
        axi_rvalid = 1'b1; axi_rdata = R1; axi_rlast = 1'b1;
        tick;
        axi_rvalid = 1'b0; axi_rlast = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin errors++; $display("FAIL rd_rsp got valid=%0b err=%0b want 1 0", rsp_valid, rsp_err); end
        checks++; if (rsp_rdata !== {R1, R0}) begin errors++; $display("FAIL rd_rdata got %h want %h", rsp_rdata, {R1, R0}); end
        finish_rsp;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rd_idle got %0b want 1", req_ready); end
    endtask

    task automatic test_write_aw_delay;
        axi_awready = 1'b0; axi_wready = 1'b1;
        axi_bvalid = 1'b1;
        send_req(1'b1, 64'h8080, {W1, W0}, '1);
        for (int i = 0; i < 5; i++) begin
            checks++; if (axi_awvalid !== 1'b1 || axi_bready !== 1'b0) begin errors++; $display("FAIL awd_wait%0d got aw=%0b bready=%0b want 1 0", i, axi_awvalid, axi_bready); end
            checks++; if (axi_wvalid !== (i < 2)) begin errors++; $display("FAIL awd_wvalid%0d got %0b want %0b", i, axi_wvalid, i < 2); end
            tick;
        end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL awd_early_rsp got %0b want 0", rsp_valid); end
        axi_awready = 1'b1;
        tick;
        checks++; if (axi_awvalid !== 1'b0 || axi_bready !== 1'b1) begin errors++; $display("FAIL awd_b_phase got aw=%0b bready=%0b want 0 1", axi_awvalid, axi_bready); end
        tick;
        axi_bvalid = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 512'd0) begin errors++; $display("FAIL awd_rsp got valid=%0b err=%0b rdata=%h want 1 0 0", rsp_valid, rsp_err, rsp_rdata); end
        finish_rsp;
        tick;
        checks++; if (rsp_valid !== 1'b0 || axi_awvalid !== 1'b0) begin errors++; $display("FAIL awd_single_rsp got rsp_valid=%0b aw=%0b want 0 0", rsp_valid, axi_awvalid); end
    endtask

    task automatic test_read_err;
        axi_arready = 1'b1;
        send_req(1'b0, 64'h4010, '0, '0);
        tick;
        axi_rvalid = 1'b1; axi_rdata = R0; axi_rresp = 2'b10; axi_rlast = 1'b0;
        tick;
        axi_rdata = R1; axi_rresp = 2'b00; axi_rlast = 1'b1;
        tick;
        axi_rvalid = 1'b0; axi_rlast = 1'b0; axi_arready = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin errors++; $display("FAIL rresp_err got valid=%0b err=%0b want 1 1", rsp_valid, rsp_err); end
        checks++; if (rsp_rdata !== {R1, R0}) begin errors++; $display("FAIL rresp_rdata got %h want %h", rsp_rdata, {R1, R0}); end
        finish_rsp;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rresp_idle got %0b want 1", req_ready); end
    endtask

    task automatic test_rlast_err;
        axi_arready = 1'b1;
        send_req(1'b0, 64'h4800, '0, '0);
        tick;
        axi_rvalid = 1'b1; axi_rdata = R1; axi_rlast = 1'b1;
        tick;
        axi_rdata = R0;
        tick;
        axi_rvalid = 1'b0; axi_rlast = 1'b0; axi_arready = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin errors++; $display("FAIL rlast_err got valid=%0b err=%0b want 1 1", rsp_valid, rsp_err); end
        checks++; if (rsp_rdata !== {R0, R1}) begin errors++; $display("FAIL rlast_rdata got %h want %h", rsp_rdata, {R0, R1}); end
        finish_rsp;
    endtask

    task automatic test_rsp_hold;
        axi_arready = 1'b1; axi_awready = 1'b1;
        send_req(1'b0, 64'h5000, '0, '0);
        tick;
        axi_rvalid = 1'b1; axi_rdata = R0; axi_rlast = 1'b0;
        tick;
        axi_rdata = R1; axi_rlast = 1'b1;
        tick;
        axi_rvalid = 1'b0; axi_rlast = 1'b0; axi_rdata = '0;
        req_valid = 1'b1; req_wr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin errors++; $display("FAIL hold%0d_rsp got valid=%0b err=%0b want 1 0", i, rsp_valid, rsp_err); end
            checks++; if (rsp_rdata !== {R1, R0}) begin errors++; $display("FAIL hold%0d_rdata got %h want %h", i, rsp_rdata, {R1, R0}); end
            checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL hold%0d_req_ready got %0b want 0", i, req_ready); end
            checks++; if (axi_awvalid !== 1'b0 || axi_wvalid !== 1'b0 || axi_arvalid !== 1'b0) begin errors++; $display("FAIL hold%0d_axi got aw=%0b w=%0b ar=%0b want 0", i, axi_awvalid, axi_wvalid, axi_arvalid); end
            tick;
        end
        req_valid = 1'b0; axi_arready = 1'b0;
        finish_rsp;
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || axi_awvalid !== 1'b0) begin errors++; $display("FAIL hold_release got rsp_valid=%0b req_ready=%0b aw=%0b want 0 1 0", rsp_valid, req_ready, axi_awvalid); end
    endtask

    task automatic test_reset_mid;
        axi_awready = 1'b1; axi_wready = 1'b1;
        send_req(1'b1, 64'h6000, {W1, W0}, '1);
        tick;
        checks++; if (axi_wvalid !== 1'b1 || axi_wlast !== 1'b1) begin errors++; $display("FAIL rmid_beat1 got w=%0b last=%0b want 1 1", axi_wvalid, axi_wlast); end
        rst_n = 1'b0;
        #1;
        checks++; if (axi_awvalid !== 1'b0 || axi_wvalid !== 1'b0 || axi_arvalid !== 1'b0) begin errors++; $display("FAIL rmid_valids got aw=%0b w=%0b ar=%0b want 0", axi_awvalid, axi_wvalid, axi_arvalid); end
        checks++; if (axi_bready !== 1'b0 || req_ready !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rmid_ctrl got bready=%0b req_ready=%0b rsp_valid=%0b want 0", axi_bready, req_ready, rsp_valid); end
        #2;
        rst_n = 1'b1;
        tick;
        checks++; if (req_ready !== 1'b1 || axi_wvalid !== 1'b0) begin errors++; $display("FAIL rmid_release got req_ready=%0b w=%0b want 1 0", req_ready, axi_wvalid); end
        send_req(1'b1, 64'h7020, {W0, W1}, {32'h0, 32'hFFFF_FFFF});
        checks++; if (axi_awvalid !== 1'b1 || axi_awaddr !== 64'h7000) begin errors++; $display("FAIL rmid_aw got valid=%0b addr=%h want 1 7000", axi_awvalid, axi_awaddr); end
        checks++; if (axi_wvalid !== 1'b1 || axi_wlast !== 1'b0 || axi_wdata !== W1 || axi_wstrb !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rmid_nb0 got w=%0b last=%0b strb=%h", axi_wvalid, axi_wlast, axi_wstrb); end
        tick;
        checks++; if (axi_wdata !== W0 || axi_wstrb !== 32'h0 || axi_wlast !== 1'b1) begin errors++; $display("FAIL rmid_nb1 got last=%0b strb=%h", axi_wlast, axi_wstrb); end
        tick;
        axi_bvalid = 1'b1;
        tick;
        axi_bvalid = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin errors++; $display("FAIL rmid_rsp got valid=%0b err=%0b want 1 0", rsp_valid, rsp_err); end
        finish_rsp;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rmid_idle got %0b want 1", req_ready); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_write_basic;
        test_write_bid_err;
        test_read;
        test_write_aw_delay;
        test_read_err;
        test_rlast_err;
        test_rsp_hold;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
